reg_dump_checker: RTL and testbench

REG_DUMP_CHECKER -- requirements
Module: reg_dump_checker

---
 rtl/reg_dump_checker.sv | 174 +++++++++++++++++
 tb/tb_reg_dump_checker.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_checker.sv
// reg_dump_checker
// Waits for an end-of-test sentinel in a register-file snapshot, or gives up
// after a bounded wait. It then walks all 32 registers, fetching one golden
// entry per register, and reports how many registers mismatch and which one
// mismatched first.
//
// Golden handshake: gold_req and gold_addr are driven straight from the FSM
// and stay stable for the whole REQ state. An entry transfers on the rising
// edge where gold_req=1 and gold_valid=1. gold_req drops on the following
// cycle (CMP), so at most one request is ever outstanding. gold_valid,
// gold_data and gold_skip are ignored in every state except REQ.
module reg_dump_checker #(
   parameter logic [31:0] SENTINEL       = 32'h0000C0DE,
   parameter int unsigned SENTINEL_REG   = 11,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1023:0] reg_flat,
   output logic          gold_req,
   output logic [4:0]    gold_addr,
   input  logic          gold_valid,
   input  logic [31:0]   gold_data,
   input  logic          gold_skip,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          timeout,
   output logic [5:0]    mismatch_count,
   output logic [4:0]    first_idx,
   output logic [31:0]   first_exp,
   output logic [31:0]   first_act,
   output logic [2:0]    dbg_state
);

   localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
   localparam int unsigned SENT_LSB = SENTINEL_REG * 32;
   localparam logic [CNT_W-1:0] WAIT_TERM = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_REQ  = 3'd2,
      ST_CMP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [4:0]       index_q, index_d;
   logic [5:0]       mismatch_count_q, mismatch_count_d;
   logic [4:0]       first_idx_q, first_idx_d;
   logic [31:0]      first_exp_q, first_exp_d;
   logic [31:0]      first_act_q, first_act_d;
   logic             timeout_q, timeout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic             sentinel_hit;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             wait_term;
   logic [31:0]      act_word;
   logic             arm;
   logic             is_mismatch;

   // Shared decode: sentinel watch, wait terminal count, compare of the current entry.
   always_comb begin
      sentinel_hit = (reg_flat[SENT_LSB +: 32] == SENTINEL);
      wait_cnt_inc = wait_cnt_q + CNT_W'(1);
      wait_term    = (wait_cnt_inc == WAIT_TERM);
      act_word     = reg_flat[{index_q, 5'b00000} +: 32];
      arm          = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      is_mismatch  = (state_q == ST_REQ) && gold_valid && !gold_skip &&
                     (gold_data != act_word);
   end

   // State register and all result flops; reset abandons any scan in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         wait_cnt_q       <= '0;
         index_q          <= '0;
         mismatch_count_q <= '0;
         first_idx_q      <= '0;
         first_exp_q      <= '0;
         first_act_q      <= '0;
         timeout_q        <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         wait_cnt_q       <= wait_cnt_d;
         index_q          <= index_d;
         mismatch_count_q <= mismatch_count_d;
         first_idx_q      <= first_idx_d;
         first_exp_q      <= first_exp_d;
         first_act_q      <= first_act_d;
         timeout_q        <= timeout_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
      end
   end

   // Next-state logic; the sentinel takes priority over the wait terminal count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_WAIT;
         ST_WAIT: if (sentinel_hit || wait_term) state_d = ST_REQ;
         ST_REQ:  if (gold_valid) state_d = ST_CMP;
         ST_CMP:  state_d = (index_q == 5'd31) ? ST_DONE : ST_REQ;
         ST_DONE: if (start) state_d = ST_WAIT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output logic: counters, mismatch bookkeeping, registered status.
   always_comb begin
      wait_cnt_d       = wait_cnt_q;
      index_d          = index_q;
      mismatch_count_d = mismatch_count_q;
      first_idx_d      = first_idx_q;
      first_exp_d      = first_exp_q;
      first_act_d      = first_act_q;
      timeout_d        = timeout_q;

      if (arm) begin
         wait_cnt_d       = '0;
         index_d          = '0;
         mismatch_count_d = '0;
         first_idx_d      = '0;
         first_exp_d      = '0;
         first_act_d      = '0;
         timeout_d        = 1'b0;
      end else if (state_q == ST_WAIT) begin
         index_d = '0;
         if (!sentinel_hit) begin
            wait_cnt_d = wait_cnt_inc;
            if (wait_term) timeout_d = 1'b1;
         end
      end else if (is_mismatch) begin
         // Only the first mismatch of a scan is captured in detail.
         if (mismatch_count_q == 6'd0) begin
            first_idx_d = index_q;
            first_exp_d = gold_data;
            first_act_d = act_word;
         end
         if (mismatch_count_q != 6'd32) mismatch_count_d = mismatch_count_q + 6'd1;
      end else if ((state_q == ST_CMP) && (index_q != 5'd31)) begin
         index_d = index_q + 5'd1;
      end

      busy_d = (state_d == ST_WAIT) || (state_d == ST_REQ) || (state_d == ST_CMP);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (mismatch_count_d == 6'd0);

      gold_req       = (state_q == ST_REQ);
      gold_addr      = index_q;
      busy           = busy_q;
      done           = done_q;
      pass           = pass_q;
      timeout        = timeout_q;
      mismatch_count = mismatch_count_q;
      first_idx      = first_idx_q;
      first_exp      = first_exp_q;
      first_act      = first_act_q;
      dbg_state      = state_q;
   end

endmodule

// File: tb/tb_reg_dump_checker.sv
// Bench for reg_dump_checker: random register files and golden tables,
// a golden-memory responder with programmable latency, and a reference
// model that derives the expected results straight from the arrays.
module tb_reg_dump_checker;

   localparam logic [31:0] SENT = 32'h0000C0DE;
   localparam int          SREG = 11;
   localparam int          TOUT = 50;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1023:0] reg_flat;
   logic          gold_req;
   logic [4:0]    gold_addr;
   logic          gold_valid;
   logic [31:0]   gold_data;
   logic          gold_skip;
   logic          busy, done, pass, timeout;
   logic [5:0]    mismatch_count;
   logic [4:0]    first_idx;
   logic [31:0]   first_exp, first_act;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs_arr [32];
   logic [31:0] gold_mem [32];
   logic        skip_mem [32];

   reg_dump_checker #(
      .SENTINEL(SENT), .SENTINEL_REG(SREG), .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .reg_flat(reg_flat),
      .gold_req(gold_req), .gold_addr(gold_addr), .gold_valid(gold_valid),
      .gold_data(gold_data), .gold_skip(gold_skip), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .mismatch_count(mismatch_count),
      .first_idx(first_idx), .first_exp(first_exp), .first_act(first_act),
      .dbg_state(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Golden memory responder: answers mem_lat cycles after the request appears.
   int         mem_lat = 0;
   bit         mem_noise = 0;
   bit         force_valid = 0;
   bit         req_active = 0;
   bit         req_served = 0;
   logic [4:0] req_addr = '0;
   int         req_wait = 0;

   initial begin
      gold_valid = 1'b0; gold_data = '0; gold_skip = 1'b0;
      forever begin
         @(negedge clk);
         if (force_valid) begin
            gold_valid = 1'b1; gold_data = $urandom; gold_skip = 1'b0;
            req_active = 0; req_served = 0;
         end else if (gold_req === 1'b1) begin
            if (req_active) begin
               checks++;
               if (req_served || gold_addr !== req_addr) begin
                  errors++;
                  $display("FAIL req_stable got addr=%0d served=%0b want addr=%0d held until served",
                           gold_addr, req_served, req_addr);
               end
            end
            if (!req_active || req_served) begin
               req_active = 1; req_served = 0; req_addr = gold_addr; req_wait = 0;
            end else begin
               req_wait++;
            end
            if (req_wait >= mem_lat) begin
               gold_valid = 1'b1;
               gold_data  = gold_mem[gold_addr];
               gold_skip  = skip_mem[gold_addr];
               req_served = 1;
            end else begin
               gold_valid = 1'b0; gold_data = $urandom; gold_skip = 1'($urandom);
            end
         end else begin
            if (req_active && !req_served && reset === 1'b1) begin
               checks++; errors++;
               $display("FAIL req_dropped got gold_req=0 want 1 at addr %0d", req_addr);
            end
            req_active = 0; req_served = 0;
            if (mem_noise) begin
               gold_valid = 1'($urandom); gold_data = $urandom; gold_skip = 1'($urandom);
            end else begin
               gold_valid = 1'b0;
            end
         end
      end
   end

   task automatic pack_regs;
      for (int i = 0; i < 32; i++) reg_flat[i*32 +: 32] = regs_arr[i];
   endtask

   // Random register file; golden entries mismatch with mm_pct percent chance.
   task automatic rand_setup(input int mm_pct, input int skip_pct, input bit use_sent);
      logic [31:0] base;
      for (int i = 0; i < 32; i++) regs_arr[i] = $urandom;
      if (regs_arr[SREG] == SENT) regs_arr[SREG] = ~SENT;
      for (int i = 0; i < 32; i++) begin
         base = (i == SREG && use_sent) ? SENT : regs_arr[i];
         gold_mem[i] = ($urandom_range(0, 99) < mm_pct) ? (base ^ ($urandom | 32'h1)) : base;
         skip_mem[i] = ($urandom_range(0, 99) < skip_pct);
      end
      pack_regs();
   endtask

   // One full scan. sent_cycle: 0 = sentinel present before start, 1..TOUT =
   // sentinel appears in that WAIT cycle, larger = never appears.
   task automatic do_scan(input string name, input int sent_cycle, input int lat,
                          input bit start_noise);
      int m, req_at, done_at, k_exp, done_lim;
      bit e_to, e_pass;
      logic [5:0] e_cnt;
      logic [4:0] e_fi;
      logic [31:0] e_fe, e_fa, act;

      mem_lat = lat;
      if (sent_cycle == 0) begin regs_arr[SREG] = SENT; pack_regs(); end

      // Reference model: expected results from the tables.
      e_cnt = 0; e_fi = 0; e_fe = 0; e_fa = 0;
      for (int i = 0; i < 32; i++) begin
         act = (i == SREG && sent_cycle <= TOUT) ? SENT : regs_arr[i];
         if (!skip_mem[i] && gold_mem[i] != act) begin
            if (e_cnt == 0) begin e_fi = 5'(i); e_fe = gold_mem[i]; e_fa = act; end
            e_cnt++;
         end
      end
      e_pass   = (e_cnt == 0);
      k_exp    = (sent_cycle <= 1) ? 1 : ((sent_cycle <= TOUT) ? sent_cycle : TOUT);
      e_to     = (sent_cycle > TOUT);
      done_lim = k_exp + 32 * (lat + 2) + 2;

      @(negedge clk); start = 1'b1;
      m = 0; req_at = 0; done_at = 0;
      while (done_at == 0 && m < 4000) begin
         @(negedge clk); m++;
         if (gold_req === 1'b1 && req_at == 0) begin
            req_at = m;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL %s_busy_in_scan got busy=%0b done=%0b want 1 0", name, busy, done);
            end
         end
         if (done === 1'b1) done_at = m;
         start = start_noise && gold_req === 1'b1 && gold_addr == 5'd10;
         if (sent_cycle >= 1 && sent_cycle <= TOUT && m == sent_cycle) begin
            regs_arr[SREG] = SENT; pack_regs();
         end
      end
      start = 1'b0;

      checks++;
      if (req_at != k_exp + 1) begin
         errors++;
         $display("FAIL %s_scan_start got cycle %0d want %0d", name, req_at, k_exp + 1);
      end
      checks++;
      if (done_at == 0 || done_at > done_lim) begin
         errors++;
         $display("FAIL %s_done_latency got %0d want 1..%0d", name, done_at, done_lim);
      end
      checks++;
      if (timeout !== e_to) begin
         errors++; $display("FAIL %s_timeout got %0b want %0b", name, timeout, e_to);
      end
      checks++;
      if (pass !== e_pass) begin
         errors++; $display("FAIL %s_pass got %0b want %0b", name, pass, e_pass);
      end
      checks++;
      if (mismatch_count !== e_cnt) begin
         errors++; $display("FAIL %s_count got %0d want %0d", name, mismatch_count, e_cnt);
      end
      checks++;
      if (first_idx !== e_fi || first_exp !== e_fe || first_act !== e_fa) begin
         errors++;
         $display("FAIL %s_first got idx=%0d exp=%h act=%h want idx=%0d exp=%h act=%h",
                  name, first_idx, first_exp, first_act, e_fi, e_fe, e_fa);
      end
      checks++;
      if (busy !== 1'b0 || gold_req !== 1'b0) begin
         errors++; $display("FAIL %s_idle_at_done got busy=%0b req=%0b want 0 0", name, busy, gold_req);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || pass !== e_pass || mismatch_count !== e_cnt || timeout !== e_to) begin
         errors++;
         $display("FAIL %s_hold got done=%0b pass=%0b cnt=%0d to=%0b want 1 %0b %0d %0b",
                  name, done, pass, mismatch_count, timeout, e_pass, e_cnt, e_to);
      end
   endtask

   task automatic test_reset;
      start = 1'b0; reg_flat = '0; reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({gold_req, gold_addr, busy, done, pass, timeout, mismatch_count, first_idx,
           first_exp, first_act, dbg_state} !== 88'd0) begin
         errors++;
         $display("FAIL reset_outputs got req=%0b addr=%0d busy=%0b done=%0b pass=%0b to=%0b cnt=%0d st=%0d want all 0",
                  gold_req, gold_addr, busy, done, pass, timeout, mismatch_count, dbg_state);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || gold_req !== 1'b0 || dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_idle got busy=%0b done=%0b req=%0b st=%0d want 0 0 0 0",
                  busy, done, gold_req, dbg_state);
      end
   endtask

   task automatic test_all_match;
      rand_setup(0, 0, 1);
      do_scan("all_match", 0, 0, 0);
   endtask

   task automatic test_two_mismatch;
      rand_setup(0, 0, 1);
      regs_arr[5] = 32'h12; gold_mem[5] = 32'h11;
      regs_arr[20] = 32'h0; gold_mem[20] = 32'hFFFFFFFF;
      pack_regs();
      do_scan("two_mismatch", 0, 1, 0);
   endtask

   task automatic test_timeout;
      rand_setup(30, 10, 0);
      do_scan("timeout", 1000, $urandom_range(0, 2), 0);
   endtask

   task automatic test_sentinel_edge;
      rand_setup(20, 0, 1);
      do_scan("sent_at_limit", TOUT, 0, 0);
      rand_setup(20, 0, 1);
      do_scan("sent_late", $urandom_range(2, TOUT - 1), 1, 0);
   endtask

   task automatic test_skip_delay;
      rand_setup(0, 0, 1);
      for (int i = 0; i < 32; i++) skip_mem[i] = (i < 4);
      for (int i = 0; i < 4; i++) gold_mem[i] = regs_arr[i] ^ 32'h0000_0100;
      do_scan("skip_delay", 0, 3, 0);
   endtask

   task automatic test_x0_and_full;
      rand_setup(0, 0, 1);
      gold_mem[0] = regs_arr[0] ^ 32'h8000_0000;
      do_scan("x0_only", 0, 0, 0);
      rand_setup(100, 0, 1);
      do_scan("all_mismatch", 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      int sc;
      mem_noise = 1;
      for (int n = 0; n < 6; n++) begin
         sc = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60);
         rand_setup($urandom_range(0, 40), $urandom_range(0, 30), sc <= TOUT);
         do_scan("b2b", sc, $urandom_range(0, 3), 1'($urandom));
      end
      mem_noise = 0;
   endtask

   task automatic test_reset_mid_scan;
      int n;
      bit found;
      rand_setup(0, 0, 1);
      gold_mem[3] = regs_arr[3] ^ 32'h1;
      regs_arr[SREG] = SENT; pack_regs();
      mem_lat = $urandom_range(0, 2);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      found = 0; n = 0;
      while (!found && n < 1000) begin
         @(negedge clk); n++;
         if (gold_req === 1'b1 && gold_addr == 5'd17) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL mid_reach_17 got no request at 17 want one within 1000 cycles");
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({gold_req, gold_addr, busy, done, pass, timeout, mismatch_count, first_idx,
           first_exp, first_act, dbg_state} !== 88'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs got req=%0b addr=%0d busy=%0b cnt=%0d st=%0d want all 0",
                  gold_req, gold_addr, busy, mismatch_count, dbg_state);
      end
      @(negedge clk);
      force_valid = 1;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      force_valid = 0;
      checks++;
      if (gold_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL mid_late_valid got req=%0b busy=%0b done=%0b st=%0d want 0 0 0 0",
                  gold_req, busy, done, dbg_state);
      end
      rand_setup(25, 10, 1);
      do_scan("after_reset", 0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_all_match();
      test_two_mismatch();
      test_timeout();
      test_sentinel_edge();
      test_skip_delay();
      test_x0_and_full();
      test_back_to_back();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
